// File: rtl/curve_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// curve_pkg : shared constants and FSM encoding for the curve LUT block
// Revision  : 1.0
// ----------------------------------------------------------------------------
package curve_pkg;

  localparam int QVAL         = 255;
  localparam int PMAX_Q       = 587;
  localparam int LUT_DEPTH    = 256;
  localparam int BUILD_LAT    = 3;
  localparam int PIX_LAT      = 2;
  localparam int BUILD_CYCLES = LUT_DEPTH + BUILD_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/curve_entry_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// curve_entry_calc : 3-stage pipelined evaluation of one curve entry lut[x]
// Revision         : 1.0
// ----------------------------------------------------------------------------
module curve_entry_calc
  import curve_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_x,
  input  logic [9:0] i_pl,
  input  logic [7:0] i_wl,
  output logic       o_valid,
  output logic [7:0] o_addr,
  output logic [7:0] o_y
);

  logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic [7:0]  s1_x_q, s1_x_d, s2_x_q, s2_x_d, s3_x_q, s3_x_d;
  logic [7:0]  s1_wl_q, s1_wl_d, s2_wl_q, s2_wl_d;
  logic [9:0]  s1_pl_q, s1_pl_d;
  logic [15:0] s1_t_q, s1_t_d;
  logic [7:0]  s2_y1_q, s2_y1_d, s3_y_q, s3_y_d;
  logic [25:0] prod;
  logic [9:0]  sum;
  logic [15:0] mix;

  always_comb begin
    // stage 1: x*(255-x), at most 16256
    s1_valid_d = i_valid;
    s1_x_d     = i_x;
    s1_pl_d    = i_pl;
    s1_wl_d    = i_wl;
    s1_t_d     = {8'd0, i_x} * {8'd0, 8'(8'd255 - i_x)};
    // stage 2: brightening term and clip
    prod       = {16'd0, s1_pl_q} * {10'd0, s1_t_q};
    sum        = {2'd0, s1_x_q} + 10'(prod >> 16);
    s2_valid_d = s1_valid_q;
    s2_x_d     = s1_x_q;
    s2_wl_d    = s1_wl_q;
    s2_y1_d    = (sum > 10'(QVAL)) ? 8'(QVAL) : sum[7:0];
    // stage 3: blend; the sum never exceeds 255*256 so 16 bits suffice
    mix        = {8'd0, s2_wl_q} * {8'd0, s2_y1_q}
               + {7'd0, 9'(9'd256 - {1'b0, s2_wl_q})} * {8'd0, s2_x_q};
    s3_valid_d = s2_valid_q;
    s3_x_d     = s2_x_q;
    s3_y_d     = 8'(mix >> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s2_valid_q <= 1'b0; s3_valid_q <= 1'b0;
      s1_x_q     <= '0;   s2_x_q     <= '0;   s3_x_q     <= '0;
      s1_wl_q    <= '0;   s2_wl_q    <= '0;   s1_pl_q    <= '0;
      s1_t_q     <= '0;   s2_y1_q    <= '0;   s3_y_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d; s2_valid_q <= s2_valid_d; s3_valid_q <= s3_valid_d;
      s1_x_q     <= s1_x_d;     s2_x_q     <= s2_x_d;     s3_x_q     <= s3_x_d;
      s1_wl_q    <= s1_wl_d;    s2_wl_q    <= s2_wl_d;    s1_pl_q    <= s1_pl_d;
      s1_t_q     <= s1_t_d;     s2_y1_q    <= s2_y1_d;    s3_y_q     <= s3_y_d;
    end
  end

  assign o_valid = s3_valid_q;
  assign o_addr  = s3_x_q;
  assign o_y     = s3_y_q;

endmodule
`default_nettype wire

// File: rtl/curve_lut_apply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// curve_lut_apply : builds a per-frame tone curve into a ping-pong LUT during
//                   vblank and maps every RGB channel through the front bank
// Revision        : 1.0
// ----------------------------------------------------------------------------
module curve_lut_apply
  import curve_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_v,
  input  logic        i_h,
  input  logic        i_de,
  input  logic [23:0] i_rgb,
  input  logic [15:0] p_q,
  input  logic [7:0]  p2_q,
  output logic        o_v,
  output logic        o_h,
  output logic        o_de,
  output logic [23:0] o_rgb,
  output logic        lut_valid,
  output logic        build_busy
);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [9:0]  pl_q, pl_d;
  logic [7:0]  wl_q, wl_d;
  logic        v_prev_q, pending_q, pending_d, sel_q, sel_d, lut_valid_q, lut_valid_d;
  logic        v_rise, v_fall, calc_in_valid, wr_valid;
  logic [7:0]  wr_addr, wr_y;
  logic        v1_q, h1_q, de1_q, v2_q, h2_q, de2_q;
  logic [23:0] rgb1_q, rgb2_q, rgb2_d;
  logic [7:0]  lut_q [2][LUT_DEPTH];

  assign v_rise = i_v & ~v_prev_q;
  assign v_fall = ~i_v & v_prev_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pl_d          = pl_q;
    wl_d          = wl_q;
    pending_d     = pending_q;
    sel_d         = sel_q;
    lut_valid_d   = lut_valid_q;
    calc_in_valid = 1'b0;
    case (state_q)
      BUILD: begin
        calc_in_valid = (cnt_q < 9'(LUT_DEPTH));
        cnt_d         = cnt_q + 9'd1;
        if (cnt_q == 9'(BUILD_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        pending_d = 1'b1;
        state_d   = IDLE;
      end
      default: ;
    endcase
    if (v_fall && pending_q) begin
      sel_d       = ~sel_q;
      lut_valid_d = 1'b1;
      pending_d   = 1'b0;
    end
    // a new frame start restarts the build; an aborted build can never be swapped in
    if (v_rise) begin
      state_d = BUILD;
      cnt_d   = '0;
      pl_d    = (p_q > 16'(PMAX_Q)) ? 10'(PMAX_Q) : p_q[9:0];
      wl_d    = p2_q;
      if (state_q == BUILD) pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pl_q        <= '0;
      wl_q        <= '0;
      v_prev_q    <= 1'b0;
      pending_q   <= 1'b0;
      sel_q       <= 1'b0;
      lut_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pl_q        <= pl_d;
      wl_q        <= wl_d;
      v_prev_q    <= i_v;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      lut_valid_q <= lut_valid_d;
    end
  end

  curve_entry_calc u_calc (
    .clk     (clk),
    .rst     (rst),
    .i_valid (calc_in_valid),
    .i_x     (cnt_q[7:0]),
    .i_pl    (pl_q),
    .i_wl    (wl_q),
    .o_valid (wr_valid),
    .o_addr  (wr_addr),
    .o_y     (wr_y)
  );

  // only the back bank is ever written
  always_ff @(posedge clk) begin
    if (wr_valid) lut_q[~sel_q][wr_addr] <= wr_y;
  end

  always_comb begin
    rgb2_d = rgb1_q;
    if (lut_valid_q)
      rgb2_d = {lut_q[sel_q][rgb1_q[23:16]], lut_q[sel_q][rgb1_q[15:8]], lut_q[sel_q][rgb1_q[7:0]]};
    if (!de1_q) rgb2_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1_q, h1_q, de1_q, v2_q, h2_q, de2_q} <= '0;
      rgb1_q <= '0;
      rgb2_q <= '0;
    end else begin
      {v1_q, h1_q, de1_q} <= {i_v, i_h, i_de};
      {v2_q, h2_q, de2_q} <= {v1_q, h1_q, de1_q};
      rgb1_q <= i_rgb;
      rgb2_q <= rgb2_d;
    end
  end

  assign o_v        = v2_q;
  assign o_h        = h2_q;
  assign o_de       = de2_q;
  assign o_rgb      = rgb2_q;
  assign lut_valid  = lut_valid_q;
  assign build_busy = (state_q == BUILD);

endmodule
`default_nettype wire

// File: tb/tb_curve_lut_apply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_curve_lut_apply : directed self-checking bench for curve_lut_apply
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_curve_lut_apply;

  logic        clk = 1'b0;
  logic        rst, i_v, i_h, i_de;
  logic [23:0] i_rgb;
  logic [15:0] p_q;
  logic [7:0]  p2_q;
  logic        o_v, o_h, o_de, lut_valid, build_busy;
  logic [23:0] o_rgb;
  int          n_asserts = 0;
  int          n_fail    = 0;

  curve_lut_apply dut (
    .clk        (clk),
    .rst        (rst),
    .i_v        (i_v),
    .i_h        (i_h),
    .i_de       (i_de),
    .i_rgb      (i_rgb),
    .p_q        (p_q),
    .p2_q       (p2_q),
    .o_v        (o_v),
    .o_h        (o_h),
    .o_de       (o_de),
    .o_rgb      (o_rgb),
    .lut_valid  (lut_valid),
    .build_busy (build_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input logic [23:0] rgb, input logic [23:0] exp);
    i_rgb = rgb;
    i_de  = 1'b1;
    tick();
    tick();
    chk(tag, {8'd0, o_rgb}, {8'd0, exp});
    i_de  = 1'b0;
  endtask

  task automatic vblank(input int n);
    i_v = 1'b1;
    repeat (n) tick();
    i_v = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; i_v = 1'b0; i_h = 1'b0; i_de = 1'b0; i_rgb = '0;
    p_q = 16'd0; p2_q = 8'd0;
    repeat (3) tick();
    chk("reset_rgb",   {8'd0, o_rgb}, 32'd0);
    chk("reset_sync",  {29'd0, o_v, o_h, o_de}, 32'd0);
    chk("reset_valid", {31'd0, lut_valid}, 32'd0);
    chk("reset_busy",  {31'd0, build_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // bypass before any swap, de gating and sync delay
    pix("bypass", 24'h123456, 24'h123456);
    chk("bypass_de", {31'd0, o_de}, 32'd1);
    chk("bypass_valid", {31'd0, lut_valid}, 32'd0);
    i_rgb = 24'hABCDEF; i_h = 1'b1; tick(); i_h = 1'b0; tick();
    chk("de_gate_zero", {8'd0, o_rgb}, 32'd0);
    chk("h_delay", {31'd0, o_h}, 32'd1);

    // p=256, w=128
    p_q = 16'd256; p2_q = 8'd128; i_v = 1'b1;
    tick();
    chk("busy_on_rise", {31'd0, build_busy}, 32'd1);
    tick();
    chk("v_delay", {31'd0, o_v}, 32'd1);
    repeat (298) tick();
    chk("busy_done", {31'd0, build_busy}, 32'd0);
    chk("no_swap_before_fall", {31'd0, lut_valid}, 32'd0);
    i_v = 1'b0;
    tick();
    chk("swap_valid", {31'd0, lut_valid}, 32'd1);
    pix("p256_w128_x128", 24'h808080, 24'h9F9F9F);
    pix("p256_w128_mix",  24'h00FF80, 24'h00FF9F);

    // p clamped to 587, w=255
    p_q = 16'd1000; p2_q = 8'd255;
    vblank(300);
    pix("clamp_w255", 24'h8000FF, 24'hFE00FF);

    // w=0 gives identity for every code
    p_q = 16'd587; p2_q = 8'd0;
    vblank(300);
    for (int x = 0; x < 256; x++) pix("identity", {3{8'(x)}}, {3{8'(x)}});

    // short vblank: build outlives the fall, old LUT kept all frame
    p_q = 16'd256; p2_q = 8'd128;
    vblank(100);
    chk("short_busy_at_fall", {31'd0, build_busy}, 32'd1);
    pix("short_old_lut_start", 24'h808080, 24'h808080);
    repeat (200) tick();
    chk("short_built", {31'd0, build_busy}, 32'd0);
    pix("short_old_lut_end", 24'h808080, 24'h808080);
    vblank(100);
    pix("short_swap_next_fall", 24'h808080, 24'h9F9F9F);
    repeat (200) tick();
    vblank(300);
    pix("long_after_short", 24'h808080, 24'h9F9F9F);

    // abort: second rise mid-build restarts with new parameters
    p_q = 16'd1000; p2_q = 8'd255; i_v = 1'b1;
    repeat (120) tick();
    i_v = 1'b0;
    pix("abort_no_swap", 24'h808080, 24'h9F9F9F);
    p_q = 16'd256; p2_q = 8'd255;
    vblank(300);
    pix("abort_new_params", 24'h8020F0, 24'hBE3AFD);

    // reset during a build returns to bypass
    i_v = 1'b1;
    repeat (50) tick();
    chk("busy_before_rst", {31'd0, build_busy}, 32'd1);
    rst = 1'b1; i_v = 1'b0;
    #2;
    chk("rst_valid", {31'd0, lut_valid}, 32'd0);
    chk("rst_busy", {31'd0, build_busy}, 32'd0);
    tick();
    rst = 1'b0;
    pix("rst_bypass", 24'h808080, 24'h808080);
    chk("rst_stays_invalid", {31'd0, lut_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
